// File: rtl/bcd_scan_display_pkg.sv
// rtl/bcd_scan_display_pkg.sv - digit codes, segment patterns and FSM states for bcd_scan_display
package bcd_scan_display_pkg;

    localparam logic [3:0] DIG_BLANK = 4'hA;
    localparam logic [3:0] DIG_DASH  = 4'hB;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CONV_L = 2'd1,
        ST_CONV_R = 2'd2,
        ST_COMMIT = 2'd3
    } conv_state_t;

    function automatic logic [6:0] seg_decode(input logic [3:0] digit);
        case (digit)
            4'd0:     return SEG_0;
            4'd1:     return SEG_1;
            4'd2:     return SEG_2;
            4'd3:     return SEG_3;
            4'd4:     return SEG_4;
            4'd5:     return SEG_5;
            4'd6:     return SEG_6;
            4'd7:     return SEG_7;
            4'd8:     return SEG_8;
            4'd9:     return SEG_9;
            DIG_DASH: return SEG_DASH;
            default:  return SEG_BLANK;
        endcase
    endfunction

endpackage

// File: rtl/bcd_scan_display_bin2bcd_seq.sv
// rtl/bcd_scan_display_bin2bcd_seq.sv - sequential subtract-10 binary to two-digit BCD converter
module bin2bcd_seq (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [6:0] bin,
    output logic       done,
    output logic [3:0] tens,
    output logic [3:0] ones
);
    import bcd_scan_display_pkg::*;

    logic [6:0] residue;
    logic [3:0] tens_cnt;
    logic       busy;
    logic       over;

    // start takes priority so a new value can load on the exit cycle of the previous one
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            residue  <= '0;
            tens_cnt <= '0;
            busy     <= 1'b0;
            over     <= 1'b0;
        end else if (start) begin
            residue  <= bin;
            tens_cnt <= '0;
            busy     <= 1'b1;
            over     <= (bin > 7'd99);
        end else if (busy) begin
            if (!over && residue >= 7'd10) begin
                residue  <= residue - 7'd10;
                tens_cnt <= tens_cnt + 4'd1;
            end else begin
                busy <= 1'b0;
            end
        end
    end

    assign done = busy && (over || residue < 7'd10);
    assign tens = over ? DIG_DASH : tens_cnt;
    assign ones = over ? DIG_DASH : residue[3:0];

endmodule

// File: rtl/bcd_scan_display.sv
// rtl/bcd_scan_display.sv - two binary values to a scanned 4-digit common-anode 7-segment display
module bcd_scan_display #(
    parameter int SCAN_DIV = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] left_val,
    input  logic [6:0] right_val,
    input  logic       blank_lead,
    input  logic       dp_on,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp,
    output logic       ready
);
    import bcd_scan_display_pkg::*;

    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    conv_state_t   state;
    logic [6:0]    shadow_l, shadow_r;
    logic [6:0]    committed_l, committed_r;
    logic [3:0]    left_tens, left_ones;
    logic [15:0]   disp;
    logic [PW-1:0] prescale;
    logic [1:0]    scan_idx;
    logic          need_pass;
    logic          conv_start, conv_done;
    logic [6:0]    conv_bin;
    logic [3:0]    conv_tens, conv_ones;
    logic [3:0]    cur_digit, shown_digit;

    // until the first commit ready is low, which doubles as the forced-first-pass flag
    assign need_pass = !ready || (left_val != committed_l) || (right_val != committed_r);

    always_comb begin
        conv_start = 1'b0;
        conv_bin   = left_val;
        if (state == ST_IDLE && need_pass) begin
            conv_start = 1'b1;
        end else if (state == ST_CONV_L && conv_done) begin
            conv_start = 1'b1;
            conv_bin   = shadow_r;
        end
    end

    bin2bcd_seq u_conv (
        .clk   (clk),
        .rst   (rst),
        .start (conv_start),
        .bin   (conv_bin),
        .done  (conv_done),
        .tens  (conv_tens),
        .ones  (conv_ones)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            shadow_l    <= '0;
            shadow_r    <= '0;
            committed_l <= '0;
            committed_r <= '0;
            left_tens   <= DIG_BLANK;
            left_ones   <= DIG_BLANK;
            disp        <= {4{DIG_BLANK}};
            ready       <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    shadow_l <= left_val;
                    shadow_r <= right_val;
                    if (need_pass) state <= ST_CONV_L;
                end
                ST_CONV_L: if (conv_done) begin
                    left_tens <= conv_tens;
                    left_ones <= conv_ones;
                    state     <= ST_CONV_R;
                end
                ST_CONV_R: if (conv_done) state <= ST_COMMIT;
                ST_COMMIT: begin
                    // converter is idle here and still holds the right-hand digits
                    disp        <= {left_tens, left_ones, conv_tens, conv_ones};
                    committed_l <= shadow_l;
                    committed_r <= shadow_r;
                    ready       <= 1'b1;
                    state       <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        cur_digit   = disp[{scan_idx, 2'b00} +: 4];
        shown_digit = cur_digit;
        if (blank_lead && scan_idx[0] && cur_digit == 4'd0) shown_digit = DIG_BLANK;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prescale <= '0;
            scan_idx <= 2'd3;
            an       <= 4'b1111;
            seg      <= SEG_BLANK;
            dp       <= 1'b1;
        end else begin
            if (prescale == PW'(SCAN_DIV - 1)) begin
                prescale <= '0;
                scan_idx <= scan_idx - 2'd1;
            end else begin
                prescale <= prescale + PW'(1);
            end
            an  <= ~(4'b0001 << scan_idx);
            seg <= seg_decode(shown_digit);
            dp  <= !(scan_idx == 2'd2 && dp_on);
        end
    end

endmodule
